serial_compare_ctrl: RTL and testbench

SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

---
 rtl/cmp_pkg.sv | 16 +
 rtl/serial_compare_ctrl_if.sv | 28 ++
 rtl/one_bit_comparator.sv | 23 ++
 rtl/serial_compare_ctrl.sv | 113 +++++++++++
 tb/tb_serial_compare_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the serial comparator: FSM encoding and the
// initial values of the greater/equal/less chain flags.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Before any bit has been examined the operands are considered equal.
    localparam logic G_RST = 1'b0;
    localparam logic E_RST = 1'b1;
    localparam logic L_RST = 1'b0;

endpackage

// File: rtl/serial_compare_ctrl_if.sv
// Operand/result handshake bundle for serial_compare_ctrl.
// Both channels use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; the producer holds its data stable
// from raising valid until that edge, and ready may be dropped at any time.
interface serial_compare_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, gt, eq, lt, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, gt, eq, lt, busy
    );
endinterface

// File: rtl/one_bit_comparator.sv
// Single bit-slice compare cell. Bits arrive LSB first, so the current
// (more significant) bit overrides the chain whenever the bits differ and
// passes the chain through unchanged when they match.
module one_bit_comparator (
    input  logic i_a,
    input  logic i_b,
    input  logic i_g,
    input  logic i_e,
    input  logic i_l,
    output logic o_g,
    output logic o_e,
    output logic o_l
);
    logic w_same;

    // Combinational slice evaluation.
    always_comb begin
        w_same = ~(i_a ^ i_b);
        o_g    = (i_a & ~i_b) | (w_same & i_g);
        o_l    = (~i_a & i_b) | (w_same & i_l);
        o_e    = w_same & i_e;
    end
endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude comparator. Operands are captured on an
// input handshake, shifted LSB first through one compare cell, and the
// gt/eq/lt result is held until the consumer accepts it.
module serial_compare_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_compare_ctrl_if.slave bus,
    output state_t               o_state
);
    // One extra counter bit lets the count reach WIDTH itself; the final
    // SHIFT cycle (count == WIDTH) closes the transaction, giving a
    // capture-to-result latency of WIDTH+1 edges.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_g;
    logic             r_e;
    logic             r_l;
    logic             w_g;
    logic             w_e;
    logic             w_l;
    logic             w_load;
    logic             w_step;
    logic             w_in_ready;
    logic             w_out_valid;

    one_bit_comparator u_cell (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_g (r_g),
        .i_e (r_e),
        .i_l (r_l),
        .o_g (w_g),
        .o_e (w_e),
        .o_l (w_l)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == LAST) w_next = DONE;
                else               w_step = 1'b1;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand shift registers, bit counter and chain flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_g   <= G_RST;
            r_e   <= E_RST;
            r_l   <= L_RST;
        end else if (w_load) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_cnt <= '0;
            r_g   <= G_RST;
            r_e   <= E_RST;
            r_l   <= L_RST;
        end else if (w_step) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CW'(1);
            r_g   <= w_g;
            r_e   <= w_e;
            r_l   <= w_l;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.gt        = w_out_valid & r_g;
    assign bus.eq        = w_out_valid & r_e;
    assign bus.lt        = w_out_valid & r_l;
    assign bus.busy      = (r_state != IDLE);
    assign o_state       = r_state;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl at WIDTH = 1, 8 and 32.
module tb_serial_compare_ctrl;
  import cmp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_compare_ctrl_if #(.WIDTH(1))  if1 ();
  serial_compare_ctrl_if #(.WIDTH(8))  if8 ();
  serial_compare_ctrl_if #(.WIDTH(32)) if32 ();
  state_t st1, st8, st32;

  serial_compare_ctrl #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1),  .o_state(st1));
  serial_compare_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8),  .o_state(st8));
  serial_compare_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32), .o_state(st32));

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];

  // Reference: {gt, eq, lt} from plain unsigned arithmetic.
  function automatic logic [2:0] model(input longint unsigned x, input longint unsigned y);
    return {x > y, x == y, x < y};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic txn8(input logic [7:0] ta, input logic [7:0] tb, input int hold, input bit scramble);
    logic [2:0] exp, got;
    int lat;
    exp_q.push_back(model(ta, tb));
    @(negedge clk);
    if8.a = ta; if8.b = tb; if8.in_valid = 1'b1; if8.out_ready = (hold == 0);
    n_cmp++;
    if (if8.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL in_ready_idle: got %b want 1", if8.in_ready);
    end
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 0;
    while (if8.out_valid !== 1'b1 && lat < 60) begin
      if (scramble) begin
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
      if (if8.out_valid !== 1'b1) begin
        n_cmp++;
        if (if8.in_ready !== 1'b0 || if8.busy !== 1'b1 || {if8.gt, if8.eq, if8.lt} !== 3'b000) begin
          n_fail++;
          $display("FAIL shift_outputs: in_ready=%b busy=%b gel=%b want 0/1/000",
                   if8.in_ready, if8.busy, {if8.gt, if8.eq, if8.lt});
        end
      end
    end
    if8.in_valid = 1'b0;
    exp = exp_q.pop_front();
    got = {if8.gt, if8.eq, if8.lt};
    n_cmp++;
    if (lat !== 9) begin n_fail++; $display("FAIL latency8: got %0d want 9", lat); end
    n_cmp++;
    if (got !== exp || if8.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL result8 a=%h b=%h: got gel=%b in_ready=%b want gel=%b in_ready=0",
                         ta, tb, got, if8.in_ready, exp);
    end
    repeat (hold) begin
      @(posedge clk); #1;
      n_cmp++;
      if (if8.out_valid !== 1'b1 || {if8.gt, if8.eq, if8.lt} !== exp || if8.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold8: out_valid=%b gel=%b in_ready=%b want 1/%b/0",
                           if8.out_valid, {if8.gt, if8.eq, if8.lt}, if8.in_ready, exp);
      end
    end
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1 || if8.busy !== 1'b0 ||
        {if8.gt, if8.eq, if8.lt} !== 3'b000) begin
      n_fail++; $display("FAIL release8: out_valid=%b in_ready=%b busy=%b gel=%b want 0/1/0/000",
                         if8.out_valid, if8.in_ready, if8.busy, {if8.gt, if8.eq, if8.lt});
    end
    if8.out_ready = 1'b0;
  endtask

  task automatic txn1(input logic ta, input logic tb);
    logic [2:0] exp;
    int lat;
    exp_q.push_back(model(ta, tb));
    @(negedge clk);
    if1.a = ta; if1.b = tb; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    lat = 0;
    while (if1.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (lat !== 2 || {if1.gt, if1.eq, if1.lt} !== exp) begin
      n_fail++; $display("FAIL result1 a=%b b=%b: got lat=%0d gel=%b want lat=2 gel=%b",
                         ta, tb, lat, {if1.gt, if1.eq, if1.lt}, exp);
    end
    @(posedge clk); #1;
    if1.out_ready = 1'b0;
  endtask

  task automatic txn32(input logic [31:0] ta, input logic [31:0] tb);
    logic [2:0] exp;
    int lat;
    exp_q.push_back(model(ta, tb));
    @(negedge clk);
    if32.a = ta; if32.b = tb; if32.in_valid = 1'b1; if32.out_ready = 1'b1;
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    lat = 0;
    while (if32.out_valid !== 1'b1 && lat < 80) begin
      @(posedge clk); #1; lat++;
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (lat !== 33 || {if32.gt, if32.eq, if32.lt} !== exp) begin
      n_fail++; $display("FAIL result32 a=%h b=%h: got lat=%0d gel=%b want lat=33 gel=%b",
                         ta, tb, lat, {if32.gt, if32.eq, if32.lt}, exp);
    end
    @(posedge clk); #1;
    if32.out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.busy !== 1'b0 ||
        {if8.gt, if8.eq, if8.lt} !== 3'b000 || st8 !== IDLE) begin
      n_fail++; $display("FAIL reset8: rdy=%b vld=%b busy=%b gel=%b st=%0d want 1/0/0/000/0",
                         if8.in_ready, if8.out_valid, if8.busy, {if8.gt, if8.eq, if8.lt}, st8);
    end
    n_cmp++;
    if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0 || if32.in_ready !== 1'b1 ||
        if32.out_valid !== 1'b0 || if1.busy !== 1'b0 || if32.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_1_32: rdy1=%b vld1=%b rdy32=%b vld32=%b want 1/0/1/0",
                         if1.in_ready, if1.out_valid, if32.in_ready, if32.out_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    txn8(8'hA5, 8'h5A, 0, 1'b0);
    txn8(8'hFF, 8'hFF, 0, 1'b0);
    txn8(8'h00, 8'h80, 0, 1'b0);
    txn8(8'h00, 8'h00, 1, 1'b0);
  endtask

  task automatic test_backpressure();
    txn8(8'h01, 8'h00, 5, 1'b0);
  endtask

  task automatic test_abort();
    bit seen;
    @(negedge clk);
    if8.a = 8'h11; if8.b = 8'h22; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (if8.in_ready !== 1'b1 || if8.busy !== 1'b0 || st8 !== IDLE) begin
      n_fail++; $display("FAIL abort_idle: in_ready=%b busy=%b st=%0d want 1/0/0",
                         if8.in_ready, if8.busy, st8);
    end
    seen = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
      if (if8.out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_result: got out_valid=1 want 0"); end
    if8.out_ready = 1'b0;
    txn8(8'd3, 8'd7, 0, 1'b0);
  endtask

  task automatic test_width_extremes();
    txn1(1'b1, 1'b0);
    txn1(1'b1, 1'b1);
    txn1(1'b0, 1'b1);
    txn32(32'h8000_0000, 32'h7FFF_FFFF);
    txn32(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    txn32(32'h0000_0001, 32'hFFFF_FFFE);
  endtask

  task automatic test_random_scramble();
    logic [7:0] ra, rb;
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? ra : 8'($urandom);
      txn8(ra, rb, $urandom_range(0, 3), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) txn8(8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 0, 1'b0);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    if1.in_valid = 1'b0;  if1.a = '0;  if1.b = '0;  if1.out_ready = 1'b0;
    if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.out_ready = 1'b0;
    if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_width_extremes();
    test_random_scramble();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule
